copro_issue_sched: RTL

//  Issue scheduler and result buffer in front of the CV-X-IF coprocessor ALU (BCD ops).
//  - Accepts issued instructions through a valid/ready handshake and queues them in an in-order FIFO.
//  - Dispatches at most one instruction per cycle to the ALU. The ALU has a fixed 1-cycle registered latency and no stall input.
//  - Uses credit-based flow control so every ALU result has a guaranteed slot in a 2-entry result buffer, which drains to the core under backpressure.

---
 rtl/copro_issue_sched_if.sv | 58 +++++
 rtl/copro_issue_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/copro_issue_sched_if.sv
// copro_issue_sched_if: issue request, ALU dispatch/result and core result channels
// of copro_issue_sched. The slave modport is the scheduler's view, master is the environment's.
interface copro_issue_sched_if #(
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned XLEN        = 32,
    parameter type         opcode_t    = logic [3:0],
    parameter type         hartid_t    = logic,
    parameter type         id_t        = logic
);
    // valid/ready: a transfer happens on each rising clk edge where valid and ready are both 1;
    // payload is meaningful only while valid is 1, and ready never depends on same-cycle valid.
    logic                                req_valid_i;
    logic                                req_ready_o;
    opcode_t                             req_opcode_i;
    hartid_t                             req_hartid_i;
    id_t                                 req_id_i;
    logic [4:0]                          req_rd_i;
    logic [NrRgprPorts-1:0][XLEN-1:0]    req_registers_i;

    opcode_t                             alu_opcode_o;
    hartid_t                             alu_hartid_o;
    id_t                                 alu_id_o;
    logic [4:0]                          alu_rd_o;
    logic [NrRgprPorts-1:0][XLEN-1:0]    alu_registers_o;

    logic                                alu_valid_i;
    logic                                alu_we_i;
    logic [XLEN-1:0]                     alu_result_i;
    hartid_t                             alu_hartid_i;
    id_t                                 alu_id_i;
    logic [4:0]                          alu_rd_i;

    logic                                res_valid_o;
    logic                                res_ready_i;
    logic [XLEN-1:0]                     res_result_o;
    hartid_t                             res_hartid_o;
    id_t                                 res_id_o;
    logic [4:0]                          res_rd_o;
    logic                                res_we_o;

    modport slave (
        input  req_valid_i, req_opcode_i, req_hartid_i, req_id_i, req_rd_i, req_registers_i,
        output req_ready_o,
        output alu_opcode_o, alu_hartid_o, alu_id_o, alu_rd_o, alu_registers_o,
        input  alu_valid_i, alu_we_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i,
        output res_valid_o, res_result_o, res_hartid_o, res_id_o, res_rd_o, res_we_o,
        input  res_ready_i
    );

    modport master (
        output req_valid_i, req_opcode_i, req_hartid_i, req_id_i, req_rd_i, req_registers_i,
        input  req_ready_o,
        input  alu_opcode_o, alu_hartid_o, alu_id_o, alu_rd_o, alu_registers_o,
        output alu_valid_i, alu_we_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i,
        input  res_valid_o, res_result_o, res_hartid_o, res_id_o, res_rd_o, res_we_o,
        output res_ready_i
    );
endinterface

// File: rtl/copro_issue_sched.sv
// copro_issue_sched: in-order issue FIFO, single dispatch per cycle to a 1-cycle ALU and a
// credit-protected 2-entry result buffer. Optional perf counters: COPRO_SCHED_PERF_CNT_EN.
module copro_issue_sched #(
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 4,
    parameter type         opcode_t    = logic [3:0],
    parameter opcode_t     OpIllegal   = '0,
    parameter type         hartid_t    = logic,
    parameter type         id_t        = logic
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    copro_issue_sched_if.slave bus
`ifdef COPRO_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]        perf_issued_o,
    output logic [31:0]        perf_stall_o
`endif
);
    localparam int unsigned     PW     = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0]   PtrMsb = {1'b1, {(PW-1){1'b0}}};

    typedef logic [NrRgprPorts-1:0][XLEN-1:0] registers_t;

    typedef struct packed {
        opcode_t    opcode;
        hartid_t    hartid;
        id_t        id;
        logic [4:0] rd;
        registers_t registers;
    } issue_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } result_t;

    issue_t        fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full;
    logic          push, dispatch, credit_ok;
    logic          inflight_q;
    issue_t        head, req_entry;

    result_t       rb_q [2];
    logic [1:0]    rb_count_q;
    logic          rb_write, rb_pop;
    result_t       alu_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PtrMsb);
    assign head       = fifo_q[rd_ptr_q[PW-2:0]];

    assign req_entry = '{opcode: bus.req_opcode_i, hartid: bus.req_hartid_i, id: bus.req_id_i,
                         rd: bus.req_rd_i, registers: bus.req_registers_i};
    assign alu_entry = '{result: bus.alu_result_i, hartid: bus.alu_hartid_i, id: bus.alu_id_i,
                         rd: bus.alu_rd_i, we: bus.alu_we_i};

    assign bus.req_ready_o = !fifo_full;
    assign push            = bus.req_valid_i && !fifo_full && !flush_i;
    assign rb_pop          = (rb_count_q != 2'd0) && bus.res_ready_i;
    assign rb_write        = bus.alu_valid_i && !flush_i;

    // A dispatch reserves a buffer slot: buffered + in-flight results, less the one leaving now, stay below 2.
    assign credit_ok = ({1'b0, rb_count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, rb_pop});
    assign dispatch  = !fifo_empty && !flush_i && credit_ok;

    assign bus.alu_opcode_o    = dispatch ? head.opcode    : OpIllegal;
    assign bus.alu_hartid_o    = dispatch ? head.hartid    : '0;
    assign bus.alu_id_o        = dispatch ? head.id        : '0;
    assign bus.alu_rd_o        = dispatch ? head.rd        : '0;
    assign bus.alu_registers_o = dispatch ? head.registers : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + PW'(1);
            if (dispatch) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q[PW-2:0]] <= req_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) inflight_q <= 1'b0;
        else       inflight_q <= dispatch;
    end

    // Head always lives in slot 0 so the core-facing fields come straight from a register.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rb_count_q <= '0;
            rb_q[0]    <= '0;
            rb_q[1]    <= '0;
        end else begin
            case ({rb_write, rb_pop})
                2'b10: begin
                    if (rb_count_q == 2'd0) rb_q[0] <= alu_entry;
                    else                    rb_q[1] <= alu_entry;
                    rb_count_q <= rb_count_q + 2'd1;
                end
                2'b01: begin
                    rb_q[0]    <= rb_q[1];
                    rb_q[1]    <= '0;
                    rb_count_q <= rb_count_q - 2'd1;
                end
                2'b11: begin
                    if (rb_count_q == 2'd1) begin
                        rb_q[0] <= alu_entry;
                    end else begin
                        rb_q[0] <= rb_q[1];
                        rb_q[1] <= alu_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_valid_o  = (rb_count_q != 2'd0);
    assign bus.res_result_o = rb_q[0].result;
    assign bus.res_hartid_o = rb_q[0].hartid;
    assign bus.res_id_o     = rb_q[0].id;
    assign bus.res_rd_o     = rb_q[0].rd;
    assign bus.res_we_o     = rb_q[0].we;

`ifdef COPRO_SCHED_PERF_CNT_EN
    logic stall;
    assign stall = !fifo_empty && !flush_i && !credit_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (dispatch && (perf_issued_o != 32'hFFFF_FFFF)) perf_issued_o <= perf_issued_o + 32'd1;
            if (stall && (perf_stall_o != 32'hFFFF_FFFF))     perf_stall_o  <= perf_stall_o + 32'd1;
        end
    end
`endif
endmodule
